signext_pipe: RTL and testbench

Pipelined, multi-format immediate extender for the LEGv8 datapath. It supersedes the single-format combinational sign extender. It accepts a 32-bit instruction word over a valid/ready handshake, classifies its format, and produces an N-bit sign- or zero-extended immediate after a configurable number of register stages. It sits between instruction fetch/decode and the ALU operand mux of the pipelined processor. Unknown encodings are flagged and counted.

---
 rtl/signext_pipe.sv | 130 +++++++++++++
 tb/tb_signext_pipe.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/signext_pipe.sv
// Pipelined multi-format LEGv8 immediate extender with a valid/ready handshake and an error counter.
// Optional feature: define SIGNEXT_SHIFT2_EN to turn B/CB offsets into byte offsets (<< 2).
module signext_pipe #(
  parameter int unsigned N     = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   a,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  y,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

`ifdef SIGNEXT_SHIFT2_EN
  localparam int unsigned BrShift = 2;
`else
  localparam int unsigned BrShift = 0;
`endif

  typedef enum logic [5:0] {
    FmtD    = 6'b000001,
    FmtCb   = 6'b000010,
    FmtB    = 6'b000100,
    FmtI    = 6'b001000,
    FmtMovz = 6'b010000,
    FmtNone = 6'b100000
  } fmt_e;

  fmt_e         w_fmt;
  logic [N-1:0] w_d_ext;
  logic [N-1:0] w_cb_ext;
  logic [N-1:0] w_b_ext;
  logic [N-1:0] w_i_ext;
  logic [N-1:0] w_movz_base;
  logic [5:0]   w_movz_sh;
  logic [N-1:0] w_y;
  logic         w_err;
  logic         w_adv;
  logic         w_out_xfer;
  logic         w_cnt_inc;

  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_err;
  logic [N-1:0]     r_y [DEPTH];
  logic [CW-1:0]    r_err_cnt;

  // Priority classification: earlier formats win on overlapping encodings.
  always_comb begin
    w_fmt = FmtNone;
    if ((a[31:21] == 11'h7C2) || (a[31:21] == 11'h7C0)) begin
      w_fmt = FmtD;
    end else if (a[31:24] == 8'hB4) begin
      w_fmt = FmtCb;
    end else if (a[31:26] == 6'b000101) begin
      w_fmt = FmtB;
    end else if (a[31:22] == 10'b1001000100) begin
      w_fmt = FmtI;
    end else if (a[31:23] == 9'b110100101) begin
      w_fmt = FmtMovz;
    end
  end

  assign w_d_ext     = {{(N-9){a[20]}}, a[20:12]};
  assign w_cb_ext    = {{(N-19){a[23]}}, a[23:5]};
  assign w_b_ext     = {{(N-26){a[25]}}, a[25:0]};
  assign w_i_ext     = {{(N-12){1'b0}}, a[21:10]};
  assign w_movz_base = {{(N-16){1'b0}}, a[20:5]};
  assign w_movz_sh   = {a[22:21], 4'b0000};

  always_comb begin
    w_y   = '0;
    w_err = 1'b0;
    unique case (w_fmt)
      FmtD:    w_y = w_d_ext;
      FmtCb:   w_y = w_cb_ext << BrShift;
      FmtB:    w_y = w_b_ext << BrShift;
      FmtI:    w_y = w_i_ext;
      FmtMovz: w_y = w_movz_base << w_movz_sh;
      FmtNone: w_err = 1'b1;
      default: w_err = 1'b1;
    endcase
  end

  // Whole pipe advances together; bubbles travel like valid slots.
  assign w_adv    = out_ready | ~r_valid[DEPTH-1];
  assign in_ready = w_adv;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_valid <= '0;
      r_err   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_y[i] <= '0;
      end
    end else if (w_adv) begin
      r_valid[0] <= in_valid;
      r_err[0]   <= w_err;
      r_y[0]     <= w_y;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_err[i]   <= r_err[i-1];
        r_y[i]     <= r_y[i-1];
      end
    end
  end

  assign out_valid = r_valid[DEPTH-1];
  assign y         = r_y[DEPTH-1];
  assign err       = r_err[DEPTH-1];

  assign w_out_xfer = out_valid & out_ready;
  assign w_cnt_inc  = w_out_xfer & err & (r_err_cnt != {CW{1'b1}});

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_cnt <= '0;
    end else if (w_cnt_inc) begin
      r_err_cnt <= r_err_cnt + CW'(1);
    end
  end

  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_signext_pipe.sv
// Directed self-checking bench for signext_pipe (N=64, DEPTH=2, CW=2).
module tb_signext_pipe;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] y;
  logic        err;
  logic [1:0]  err_cnt;

  int n_pass;
  int n_total;

  localparam logic [31:0] W_LDUR = 32'hF85F8041;
  localparam logic [31:0] W_STUR = 32'hF80FF000;
  localparam logic [31:0] W_CBZ  = 32'hB4FFFFE3;
  localparam logic [31:0] W_B    = 32'h14000004;
  localparam logic [31:0] W_BNEG = 32'h17FFFFFF;
  localparam logic [31:0] W_ADDI = 32'h913FFC00;
  localparam logic [31:0] W_MOVZ = 32'hD2D579A0;

  localparam logic [63:0] Y_LDUR = 64'hFFFF_FFFF_FFFF_FFF8;
  localparam logic [63:0] Y_STUR = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] Y_ADDI = 64'h0000_0000_0000_0FFF;
  localparam logic [63:0] Y_MOVZ = 64'h0000_ABCD_0000_0000;
`ifdef SIGNEXT_SHIFT2_EN
  localparam logic [63:0] Y_CBZ  = 64'hFFFF_FFFF_FFFF_FFFC;
  localparam logic [63:0] Y_B    = 64'd16;
  localparam logic [63:0] Y_BNEG = 64'hFFFF_FFFF_FFFF_FFFC;
`else
  localparam logic [63:0] Y_CBZ  = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] Y_B    = 64'd4;
  localparam logic [63:0] Y_BNEG = 64'hFFFF_FFFF_FFFF_FFFF;
`endif

  signext_pipe #(
    .N    (64),
    .DEPTH(2),
    .CW   (2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pipe must be empty with out_ready=1 on entry.
  task automatic send_check(input string tag, input logic [31:0] word, input logic [63:0] exp_y,
                            input logic exp_err);
    a        = word;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    a        = 32'h0;
    chk({tag, "_lat"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_y"}, y, exp_y);
    chk({tag, "_err"}, 64'(err), 64'(exp_err));
    tick();
    chk({tag, "_once"}, 64'(out_valid), 64'd0);
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a         = 32'h0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    chk("rst_y", y, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_in_ready", 64'(in_ready), 64'd1);

    send_check("ldur", W_LDUR, Y_LDUR, 1'b0);
    send_check("stur", W_STUR, Y_STUR, 1'b0);
    send_check("cbz", W_CBZ, Y_CBZ, 1'b0);
    send_check("b", W_B, Y_B, 1'b0);
    send_check("bneg", W_BNEG, Y_BNEG, 1'b0);
    send_check("addi", W_ADDI, Y_ADDI, 1'b0);
    send_check("movz", W_MOVZ, Y_MOVZ, 1'b0);
    chk("cnt_after_good", 64'(err_cnt), 64'd0);

    send_check("err0", 32'h0, 64'd0, 1'b1);
    chk("cnt1", 64'(err_cnt), 64'd1);
    send_check("err1", 32'hFFFF_FFFF, 64'd0, 1'b1);
    chk("cnt2", 64'(err_cnt), 64'd2);
    send_check("err2", 32'h1234_5678, 64'd0, 1'b1);
    chk("cnt3", 64'(err_cnt), 64'd3);
    send_check("err3", 32'h0, 64'd0, 1'b1);
    chk("cnt_sat4", 64'(err_cnt), 64'd3);
    send_check("err4", 32'h0, 64'd0, 1'b1);
    chk("cnt_sat5", 64'(err_cnt), 64'd3);

    // Back-to-back stream with a 3-cycle stall while W_LDUR sits at the output.
    in_valid = 1'b1;
    a        = W_LDUR;
    tick();
    a = W_B;
    tick();
    chk("bp_w0_vld", 64'(out_valid), 64'd1);
    chk("bp_w0_y", y, Y_LDUR);
    out_ready = 1'b0;
    a         = W_ADDI;
    #1;
    chk("bp_in_ready_low", 64'(in_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_stall_vld", 64'(out_valid), 64'd1);
      chk("bp_stall_y", y, Y_LDUR);
      chk("bp_stall_rdy", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_w1_vld", 64'(out_valid), 64'd1);
    chk("bp_w1_y", y, Y_B);
    a = W_MOVZ;
    tick();
    chk("bp_w2_vld", 64'(out_valid), 64'd1);
    chk("bp_w2_y", y, Y_ADDI);
    in_valid = 1'b0;
    a        = 32'h0;
    tick();
    chk("bp_w3_vld", 64'(out_valid), 64'd1);
    chk("bp_w3_y", y, Y_MOVZ);
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);
    chk("bp_cnt_kept", 64'(err_cnt), 64'd3);

    // Reset with two words in flight.
    in_valid = 1'b1;
    a        = W_LDUR;
    tick();
    a = W_CBZ;
    tick();
    in_valid = 1'b0;
    a        = 32'h0;
    chk("mid_pre_vld", 64'(out_valid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("mid_rst_vld", 64'(out_valid), 64'd0);
    chk("mid_rst_cnt", 64'(err_cnt), 64'd0);
    chk("mid_rst_rdy", 64'(in_ready), 64'd1);
    chk("mid_rst_y", y, 64'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_empty", 64'(out_valid), 64'd0);
    end
    chk("post_rst_cnt", 64'(err_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
